// File: rtl/rv32_pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv32_types : shared types for the RV32 pipeline controller.
//   pipe_ctrl_state_t : controller FSM state (RUN, MEM_WAIT, HALT)
//   PERF_CNT_W        : width of the performance counters
// ----------------------------------------------------------------------------
package rv32_types;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_ctrl_state_t;

    localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/rv32_perf_counter.sv
// ----------------------------------------------------------------------------
// rv32_perf_counter : 32-bit event counter, wraps from all-ones to zero.
//   clk   in  : core clock
//   clr_n in  : asynchronous active-low clear
//   en    in  : count this cycle
//   count out : current count (registered)
// ----------------------------------------------------------------------------
module rv32_perf_counter
    import rv32_types::*;
(
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    output logic [PERF_CNT_W-1:0] count
);

    logic [PERF_CNT_W-1:0] count_r;

    // Event counter; natural overflow gives the wrap to zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_r <= {PERF_CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// rv32_pipeline_ctrl : stall / flush / halt controller for a 5-stage RV32 core.
//   Inputs : clk, resetn (async active-low), hazard_stall, branch_taken,
//            dmem_req, dmem_ready, halt_req, resume
//   Outputs: fetch_en, fd_en, de_en, em_en, mw_en (PC / buffer write enables),
//            fd_flush, de_flush (load NOP), pc_redirect, state, halted
//   Option : RV32_PERF_CNT_EN adds stall_cycles, flush_events, mem_wait_cycles.
// Control outputs are combinational from state and inputs (zero latency);
// event priority is mem wait > halt > branch > hazard stall.
// ----------------------------------------------------------------------------
module rv32_pipeline_ctrl
    import rv32_types::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             fetch_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             pc_redirect,
    output pipe_ctrl_state_t state,
    output logic             halted
`ifdef RV32_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
    output logic [31:0]      mem_wait_cycles
`endif
);

    pipe_ctrl_state_t state_r;
    pipe_ctrl_state_t next_state_s;
    logic             mem_wait_s;

    // A zero-wait access (ready with the request) is not a memory event.
    assign mem_wait_s = dmem_req & ~dmem_ready;

    // Next-state and pipeline control decode.
    always_comb begin
        next_state_s = state_r;
        fetch_en     = 1'b0;
        fd_en        = 1'b0;
        de_en        = 1'b0;
        em_en        = 1'b0;
        mw_en        = 1'b0;
        fd_flush     = 1'b0;
        de_flush     = 1'b0;
        pc_redirect  = 1'b0;
        if (!resetn) begin
            // Hold the pipeline frozen and filled with NOPs while in reset.
            fd_flush     = 1'b1;
            de_flush     = 1'b1;
            next_state_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_wait_s) begin
                        next_state_s = MEM_WAIT;
                    end else if (halt_req) begin
                        // Let the ebreak retire, freeze everything upstream.
                        mw_en        = 1'b1;
                        next_state_s = HALT;
                    end else if (branch_taken) begin
                        // Wrong-path instructions squashed; any hazard is moot.
                        {fetch_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                        fd_flush    = 1'b1;
                        de_flush    = 1'b1;
                        pc_redirect = 1'b1;
                    end else if (hazard_stall) begin
                        // Hold PC and F/D, inject one bubble into D/E.
                        {de_en, em_en, mw_en} = 3'b111;
                        de_flush              = 1'b1;
                    end else begin
                        {fetch_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        {fetch_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                        next_state_s = RUN;
                    end else begin
                        next_state_s = MEM_WAIT;
                    end
                end
                HALT: begin
                    if (resume) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = HALT;
                    end
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    assign state  = state_r;
    assign halted = (state_r == HALT);

`ifdef RV32_PERF_CNT_EN
    logic stall_evt_s;
    logic flush_evt_s;
    logic memw_evt_s;

    // Event strobes mirror the RUN-state priority chain above.
    assign stall_evt_s = (state_r == RUN) & ~mem_wait_s & ~halt_req & ~branch_taken & hazard_stall;
    assign flush_evt_s = (state_r == RUN) & ~mem_wait_s & ~halt_req & branch_taken;
    // The ready cycle of MEM_WAIT is a completing cycle, not a wait cycle.
    assign memw_evt_s  = ((state_r == RUN) & mem_wait_s) | ((state_r == MEM_WAIT) & ~dmem_ready);

    rv32_perf_counter u_stall_cnt (
        .clk   (clk),
        .clr_n (resetn),
        .en    (stall_evt_s),
        .count (stall_cycles)
    );

    rv32_perf_counter u_flush_cnt (
        .clk   (clk),
        .clr_n (resetn),
        .en    (flush_evt_s),
        .count (flush_events)
    );

    rv32_perf_counter u_memw_cnt (
        .clk   (clk),
        .clr_n (resetn),
        .en    (memw_evt_s),
        .count (mem_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rv32_pipeline_ctrl : scoreboard bench for rv32_pipeline_ctrl.
// Each stimulus cycle pushes its expected control vector; a negedge monitor
// pops and compares. Counter checks compile only with RV32_PERF_CNT_EN.
// ----------------------------------------------------------------------------
module tb_rv32_pipeline_ctrl;
    import rv32_types::*;

    logic clk = 1'b0;
    logic resetn, hazard_stall, branch_taken, dmem_req, dmem_ready, halt_req, resume;
    logic fetch_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, pc_redirect, halted;
    pipe_ctrl_state_t state;
`ifdef RV32_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    rv32_pipeline_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .fetch_en     (fetch_en),
        .fd_en        (fd_en),
        .de_en        (de_en),
        .em_en        (em_en),
        .mw_en        (mw_en),
        .fd_flush     (fd_flush),
        .de_flush     (de_flush),
        .pc_redirect  (pc_redirect),
        .state        (state),
        .halted       (halted)
`ifdef RV32_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .mem_wait_cycles (mem_wait_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare the vector expected for this cycle, mid-cycle.
    always @(negedge clk) begin
        logic [10:0] e;
        string       t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, {21'd0, fetch_en, fd_en, de_en, em_en, mw_en,
                         fd_flush, de_flush, pc_redirect, halted, 2'(state)},
                     {21'd0, e});
        end
    end

    // One cycle: drive inputs, queue expected outputs, advance past the edge.
    // in = {hazard_stall, branch_taken, dmem_req, dmem_ready, halt_req, resume}
    // en = {fetch, fd, de, em, mw}; fl = {fd_flush, de_flush}
    task automatic step(input string tag, input logic [5:0] in, input logic [4:0] en,
                        input logic [1:0] fl, input logic pcr, input logic hlt,
                        input pipe_ctrl_state_t st);
        {hazard_stall, branch_taken, dmem_req, dmem_ready, halt_req, resume} = in;
        exp_q.push_back({en, fl, pcr, hlt, 2'(st)});
        tag_q.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        {hazard_stall, branch_taken, dmem_req, dmem_ready, halt_req, resume} = 6'b000000;
        step("reset",      6'b000000, 5'b00000, 2'b11, 1'b0, 1'b0, RUN);
        resetn = 1'b1;
        step("idle0",      6'b000000, 5'b11111, 2'b00, 1'b0, 1'b0, RUN);
        step("hazard",     6'b100000, 5'b00111, 2'b01, 1'b0, 1'b0, RUN);
`ifdef RV32_PERF_CNT_EN
        check_eq("stall_cnt_1", stall_cycles, 32'd1);
`endif
        step("post_haz",   6'b000000, 5'b11111, 2'b00, 1'b0, 1'b0, RUN);
        step("br_haz",     6'b110000, 5'b11111, 2'b11, 1'b1, 1'b0, RUN);
`ifdef RV32_PERF_CNT_EN
        check_eq("stall_cnt_br", stall_cycles, 32'd1);
        check_eq("flush_cnt_1",  flush_events, 32'd1);
`endif
        step("zero_wait",  6'b001100, 5'b11111, 2'b00, 1'b0, 1'b0, RUN);
        step("mem_start",  6'b011010, 5'b00000, 2'b00, 1'b0, 1'b0, RUN);
        step("mem_w1",     6'b011000, 5'b00000, 2'b00, 1'b0, 1'b0, MEM_WAIT);
        step("mem_w2",     6'b101000, 5'b00000, 2'b00, 1'b0, 1'b0, MEM_WAIT);
        step("mem_ready",  6'b001100, 5'b11111, 2'b00, 1'b0, 1'b0, MEM_WAIT);
`ifdef RV32_PERF_CNT_EN
        check_eq("memw_cnt_3",  mem_wait_cycles, 32'd3);
        check_eq("flush_cnt_mw", flush_events, 32'd1);
`endif
        step("post_mem",   6'b000000, 5'b11111, 2'b00, 1'b0, 1'b0, RUN);
        step("halt_req",   6'b110010, 5'b00001, 2'b00, 1'b0, 1'b0, RUN);
        for (int i = 0; i < 5; i++) begin
            step("halted",  6'b010000, 5'b00000, 2'b00, 1'b0, 1'b1, HALT);
        end
        step("resume",     6'b000001, 5'b00000, 2'b00, 1'b0, 1'b1, HALT);
        step("post_res",   6'b000000, 5'b11111, 2'b00, 1'b0, 1'b0, RUN);
`ifdef RV32_PERF_CNT_EN
        check_eq("flush_cnt_halt", flush_events, 32'd1);
        check_eq("stall_cnt_halt", stall_cycles, 32'd1);
`endif
        step("haz_zw",     6'b101100, 5'b00111, 2'b01, 1'b0, 1'b0, RUN);
`ifdef RV32_PERF_CNT_EN
        check_eq("stall_cnt_2", stall_cycles, 32'd2);
`endif
        step("mem_start2", 6'b001000, 5'b00000, 2'b00, 1'b0, 1'b0, RUN);
        step("mem_w3",     6'b001000, 5'b00000, 2'b00, 1'b0, 1'b0, MEM_WAIT);
        resetn = 1'b0;
        step("rst_memw",   6'b001000, 5'b00000, 2'b11, 1'b0, 1'b0, RUN);
`ifdef RV32_PERF_CNT_EN
        check_eq("rst_stall", stall_cycles, 32'd0);
        check_eq("rst_flush", flush_events, 32'd0);
        check_eq("rst_memw",  mem_wait_cycles, 32'd0);
`endif
        resetn = 1'b1;
        step("post_rst",   6'b000000, 5'b11111, 2'b00, 1'b0, 1'b0, RUN);
`ifdef RV32_PERF_CNT_EN
        force dut.u_stall_cnt.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.count_r;
        check_eq("preload", stall_cycles, 32'hFFFF_FFFF);
        step("haz_wrap",   6'b100000, 5'b00111, 2'b01, 1'b0, 1'b0, RUN);
        check_eq("stall_wrap", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_pipeline_ctrl.md
RV32_PIPELINE_CTRL -- requirements
Module: rv32_pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 core clock; resetn in 1 asynchronous active-low reset.
REQ-002 SHALL have ports: hazard_stall in 1 load-use stall request from hazard detection; branch_taken in 1 exec-stage redirect; dmem_req in 1 mem stage issues data access; dmem_ready in 1 data memory completes access; halt_req in 1 ebreak at wb; resume in 1 external restart.
REQ-003 SHALL have ports: fetch_en, fd_en, de_en, em_en, mw_en out 1 each, PC and pipeline-buffer write enables; fd_flush, de_flush out 1 each, load NOP into buffer; pc_redirect out 1 select branch target.
REQ-004 SHALL have ports: state out pipe_ctrl_state_t current FSM state; halted out 1.
REQ-005 SHALL have ports, only with RV32_PERF_CNT_EN: stall_cycles, flush_events, mem_wait_cycles out 32 each.

Function
REQ-006 SHALL implement FSM states RUN, MEM_WAIT, HALT; state registered, outputs combinational from state and inputs.
REQ-007 RUN, no events: all enables 1, flushes 0, pc_redirect 0.
REQ-008 RUN, dmem_req=1 and dmem_ready=0: all enables 0, flushes 0, next state MEM_WAIT; lower-priority events ignored this cycle.
REQ-009 RUN, dmem_req=1 and dmem_ready=1: treated as no memory event (zero-wait access).
REQ-010 RUN, branch_taken=1 (no mem wait): pc_redirect 1, fd_flush 1, de_flush 1, all enables 1; hazard_stall ignored (wrong-path instruction).
REQ-011 RUN, hazard_stall=1, no branch, no mem wait: fetch_en 0, fd_en 0, de_flush 1, de_en 1, em_en 1, mw_en 1 (one bubble per asserted cycle).
REQ-012 MEM_WAIT: all enables 0, flushes 0; on dmem_ready=1 enables all 1 that cycle and return to RUN; branch_taken/hazard_stall sampled only in RUN.
REQ-013 RUN, halt_req=1 (no mem wait): mw_en 1, all other enables 0, flushes 0, next state HALT.
REQ-014 HALT: all enables 0, halted 1; resume=1 returns to RUN next cycle with no flush.
REQ-015 Priority SHALL be mem wait > halt > branch > hazard stall.
REQ-016 Control output latency: zero cycles from inputs; state change: one cycle.

Reset
REQ-017 On resetn=0 state SHALL go to RUN asynchronously; halted 0; counters 0.
REQ-018 Outputs during reset SHALL be all enables 0, flushes 1, pc_redirect 0; reset mid-MEM_WAIT/HALT abandons access/halt.

Configuration
REQ-019 Macro RV32_PERF_CNT_EN: defined -> counters present; stall_cycles +1 per REQ-011 cycle, flush_events +1 per REQ-010 cycle, mem_wait_cycles +1 per cycle in MEM_WAIT or REQ-008 cycle; wrap at 2^32-1 to 0.
REQ-020 Undefined -> counter ports and logic absent; FSM behaviour unchanged.

Structure
REQ-021 pipe_ctrl_state_t enum (RUN, MEM_WAIT, HALT) SHALL live in rv32_types package.
REQ-022 Counters SHALL use one sub-module rv32_perf_counter (32-bit, enable, async active-low clear), instantiated three times.

Verification
REQ-023 hazard_stall=1 one cycle in RUN -> fetch_en=0, fd_en=0, de_flush=1; next cycle all enables 1; stall_cycles=1.
REQ-024 branch_taken=1 and hazard_stall=1 same cycle -> pc_redirect=1, fd_flush=de_flush=1, fetch_en=1; stall_cycles unchanged, flush_events=1.
REQ-025 dmem_req=1, dmem_ready low 3 cycles then high -> enables 0 for 3 cycles, state MEM_WAIT, enables 1 on ready cycle, mem_wait_cycles=3.
REQ-026 halt_req=1 -> mw_en=1 that cycle; halted=1 next; resume=1 after 5 cycles -> RUN, enables 1.
REQ-027 resetn=0 asserted mid-MEM_WAIT -> immediate RUN, flushes 1, counters 0; after release first cycle enables 1.
REQ-028 stall_cycles preloaded via force to 32'hFFFFFFFF, one stall -> 0.
